pipeline_sink: RTL
==================

// Module: pipeline_sink
// PURPOSE
//  Receiving end of the valid/ready value stream emitted by the pipeline stages.
//  Drives o_ready with a programmable rotating backpressure pattern.
//  Checks accepted values against an incrementing sequence; counts beats and mismatches.
//  Used as the downstream load for pipeline stages in block benches and on-chip self-test.
// PARAMETERS
//  VALUE_BITS    8   width of stream value
//  COUNT_BITS    16  width of length, beat and error counters
//  PATTERN_BITS  8   width of the ready backpressure pattern
//  TIMEOUT_BITS  10  watchdog width; used only with PIPELINE_SINK_TIMEOUT_EN
// PORTS
//  clock        in   1             rising-edge clock
//  reset        in   1             synchronous, active-high reset
//  i_start      in   1             pulse; begin a run (honoured in IDLE only)
//  i_seed       in   VALUE_BITS    expected value of first beat
//  i_length     in   COUNT_BITS    beats to receive in this run
//  i_pattern    in   PATTERN_BITS  ready pattern, bit0 first, rotates right
//  i_value      in   VALUE_BITS    stream value from upstream
//  i_valid      in   1             stream valid from upstream
//  o_ready      out  1             stream ready, registered
//  o_busy       out  1             1 while in RECV
//  o_done       out  1             one-cycle pulse at end of run
//  o_count      out  COUNT_BITS    beats accepted in current/last run
//  o_errors     out  COUNT_BITS    mismatches, saturating at all-ones
//  o_err_value  out  VALUE_BITS    value of first mismatching beat
//  o_timeout    out  1             run ended by watchdog (macro only, else tied 0)
// BEHAVIOUR
//  - Synchronous reset: state=IDLE; every output 0; pattern, expected, counters 0.
//  - Reset mid-run: abandons the run; no o_done; all outputs 0 after that edge.
//  - Handshake: beat accepted on a clock edge with i_valid & o_ready.
//    Sink never requires i_valid before raising ready.
//    Upstream value/valid stability is not checked.
//  - FSM IDLE -> RECV -> DONE -> IDLE.
//  - IDLE, i_start=1, length==0: go to DONE.
//    Latch i_seed into expected. Clear count, errors and err_value.
//  - IDLE, i_start=1, length!=0: go to RECV. Same latching as above.
//    Latch i_pattern into the pattern register; an all-zero pattern is loaded as all-ones.
//  - RECV, ready generation:
//    Pattern register rotates right by one every cycle, independent of accepts.
//    o_ready is registered: o_ready(next) = (next state == RECV) & pattern bit0 after rotation.
//    First ready can appear on the cycle after entering RECV.
//  - RECV, on each accept:
//    count += 1.
//    If i_value != expected: errors += 1 (saturating). On the first mismatch only, err_value <= i_value.
//    expected += 1, wrapping modulo 2^VALUE_BITS.
//  - RECV, last beat: accept with count == i_length-1 (length latched at start) -> DONE.
//    o_ready is 0 on the following cycle.
//  - DONE: o_done=1, o_ready=0, o_busy=0 for exactly one cycle, then IDLE.
//  - Results: count, errors and err_value hold until the next i_start.
//  - i_start outside IDLE is ignored; i_seed, i_length and i_pattern are sampled only at start.
//  - i_valid while not ready is never accepted; the beat is neither counted nor checked.
// CONFIGURATION
//  PIPELINE_SINK_TIMEOUT_EN defined:
//    Watchdog counter clears on entering RECV and on every accept; increments on other RECV cycles.
//    On reaching 2^TIMEOUT_BITS-1 it forces DONE with o_timeout=1.
//    o_timeout holds until the next i_start.
//  Undefined: no watchdog; o_timeout tied 0; a stalled upstream keeps the sink in RECV indefinitely.
// TESTING
//  T1 seed=0x10, len=4, pattern=0xFF, upstream 0x10..0x13 back-to-back
//     -> 4 accepts on consecutive cycles, count=4, errors=0, o_done 1 cycle.
//  T2 pattern=0x05 (0b00000101), len=3, valid always 1
//     -> ready high 2 of every 8 cycles, accepts only then; count=3, errors=0.
//  T3 seed=0xFE, len=4, send 0xFE,0xFF,0x00,0x01 -> errors=0, wrap-around passes.
//  T4 seed=0, len=3, send 0,7,2 -> errors=1, err_value=0x07, count=3.
//  T5 reset asserted after beat 2 of len=8 -> next cycle all outputs 0, no o_done.
//     Then a new i_start runs normally.
//  T6 len=0 -> o_done next cycle, no ready; (macro) len=2, valid held 0
//     -> o_timeout=1 and o_done after 1023 RECV cycles.

Source files
------------

// File: rtl/pipeline_sink.sv
// pipeline_sink: receiving end of a valid/ready value stream.
// Presents a rotating backpressure pattern on o_ready and checks accepted
// values against an incrementing sequence, counting beats and mismatches.
// Optional watchdog: define PIPELINE_SINK_TIMEOUT_EN to end a stalled run
// after 2^TIMEOUT_BITS-1 cycles without an accept.
//
// state | meaning
// IDLE  | waiting for i_start; results of last run held
// RECV  | run active, ready driven from the rotating pattern
// DONE  | one-cycle end-of-run pulse, then back to IDLE

module pipeline_sink #(
    parameter int VALUE_BITS   = 8,
    parameter int COUNT_BITS   = 16,
    parameter int PATTERN_BITS = 8,
    parameter int TIMEOUT_BITS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [VALUE_BITS-1:0]   i_seed,
    input  logic [COUNT_BITS-1:0]   i_length,
    input  logic [PATTERN_BITS-1:0] i_pattern,
    input  logic [VALUE_BITS-1:0]   i_value,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [COUNT_BITS-1:0]   o_count,
    output logic [COUNT_BITS-1:0]   o_errors,
    output logic [VALUE_BITS-1:0]   o_err_value,
    output logic                    o_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [COUNT_BITS-1:0] ONE_C = COUNT_BITS'(1);
    localparam logic [VALUE_BITS-1:0] ONE_V = VALUE_BITS'(1);

    logic [1:0]              state;
    logic [PATTERN_BITS-1:0] pattern;
    logic [PATTERN_BITS-1:0] pattern_rot;
    logic [PATTERN_BITS-1:0] pattern_load;
    logic [VALUE_BITS-1:0]   expected;
    logic [VALUE_BITS-1:0]   err_value;
    logic [COUNT_BITS-1:0]   length;
    logic [COUNT_BITS-1:0]   count;
    logic [COUNT_BITS-1:0]   errors;
    logic                    ready;
    logic                    accept;
    logic                    last_beat;
    logic                    mismatch;

`ifdef PIPELINE_SINK_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] wd;
    logic                    wd_expire;
    logic                    timeout;

    // Watchdog fires on the cycle that would take it to all-ones.
    always_comb begin
        wd_expire = (wd == {{(TIMEOUT_BITS-1){1'b1}}, 1'b0});
    end

    assign o_timeout = timeout;
`else
    // No watchdog in this build; the width parameter has no effect here.
    assign o_timeout = (TIMEOUT_BITS < 0);
`endif

    // Handshake, pattern rotation and end-of-run decode.
    always_comb begin
        pattern_rot  = {pattern[0], pattern[PATTERN_BITS-1:1]};
        pattern_load = (i_pattern == '0) ? '1 : i_pattern;
        accept       = (state == ST_RECV) && i_valid && ready;
        last_beat    = (count == (length - ONE_C));
        mismatch     = (i_value != expected);
    end

    // Run sequencing, ready generation and result accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            pattern   <= '0;
            expected  <= '0;
            length    <= '0;
            count     <= '0;
            errors    <= '0;
            err_value <= '0;
            ready     <= 1'b0;
`ifdef PIPELINE_SINK_TIMEOUT_EN
            wd        <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ready <= 1'b0;
                    if (i_start) begin
                        expected  <= i_seed;
                        length    <= i_length;
                        count     <= '0;
                        errors    <= '0;
                        err_value <= '0;
`ifdef PIPELINE_SINK_TIMEOUT_EN
                        wd        <= '0;
                        timeout   <= 1'b0;
`endif
                        if (i_length == '0) begin
                            state <= ST_DONE;
                        end else begin
                            // ready always mirrors pattern bit0 while receiving
                            state   <= ST_RECV;
                            pattern <= pattern_load;
                            ready   <= pattern_load[0];
                        end
                    end
                end
                ST_RECV: begin
                    pattern <= pattern_rot;
                    ready   <= pattern_rot[0];
                    if (accept) begin
                        count    <= count + ONE_C;
                        expected <= expected + ONE_V;
                        if (mismatch) begin
                            if (errors != '1) errors <= errors + ONE_C;
                            if (errors == '0) err_value <= i_value;
                        end
                        if (last_beat) begin
                            state <= ST_DONE;
                            ready <= 1'b0;
                        end
`ifdef PIPELINE_SINK_TIMEOUT_EN
                        wd <= '0;
`endif
                    end
`ifdef PIPELINE_SINK_TIMEOUT_EN
                    else if (wd_expire) begin
                        state   <= ST_DONE;
                        ready   <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready     = ready;
    assign o_busy      = (state == ST_RECV);
    assign o_done      = (state == ST_DONE);
    assign o_count     = count;
    assign o_errors    = errors;
    assign o_err_value = err_value;

endmodule
